axis_tx_pkt_arbiter: RTL and testbench
======================================

# axis_tx_pkt_arbiter

Packet-granular 2:1 arbiter that merges two 128-bit AXI4-Stream TX sources into the single stream feeding the TX downsizer/FIFO path (S01 side of the interconnect). A grant is held from the first beat of a packet until its TLAST beat is accepted, so packets are never interleaved. The output is registered through a full-throughput skid buffer to close timing at the user clock.

## Interface
- C_TDATA_WIDTH, 128, data width of both inputs and the output.
- C_TUSER_WIDTH, 8, TUSER width, passed through unmodified.
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- S00_AXIS_TVALID / S01_AXIS_TVALID  in  1  source valid.
- S00_AXIS_TREADY / S01_AXIS_TREADY  out  1  source ready.
- S0x_AXIS_TDATA  in  C_TDATA_WIDTH  source data.
- S0x_AXIS_TSTRB  in  C_TDATA_WIDTH/8  byte strobes.
- S0x_AXIS_TLAST  in  1  end of packet.
- S0x_AXIS_TUSER  in  C_TUSER_WIDTH  sideband.
- M_AXIS_TVALID  out  1  merged valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA / TSTRB / TLAST / TUSER  out  as above  merged stream.
- GRANT  out  2  one-hot current owner (bit0 = S00, bit1 = S01), 2'b00 when idle.

## Operation
- States: IDLE, OWN0, OWN1, encoded 2 bits.
- IDLE: if any TVALID is high, pick the winner and move to OWN0/OWN1 next cycle. The arbitration policy is given under Configuration.
- OWNn: S0n_AXIS_TREADY = slice-ready. The other source's TREADY = 0. Beats of S0n are forwarded unchanged, with TDATA/TSTRB/TLAST/TUSER bit-exact.
- Packet end: on the cycle the S0n TLAST beat is accepted (TVALID & TREADY & TLAST), re-arbitrate using the current TVALIDs.
  - Next state is OWN of the winner, or IDLE if neither source is valid.
  - A back-to-back packet therefore has zero bubble.
- last_grant register: updated to n when a packet from S0n completes. It is used for round-robin.
- A single-beat packet (TLAST on the first beat) is legal. It both opens and closes the grant.
- Skid buffer: 2-entry.
  - Slice-ready is registered and equals "buffer not full".
  - The skid buffer sustains 1 beat/cycle under continuous M_AXIS_TREADY.
  - M_AXIS_TVALID deasserts only when the buffer is empty.
- Reset mid-packet: the state returns to IDLE and the buffer is flushed. The partial packet is dropped downstream, and the sources are responsible for restarting.
- A source dropping TVALID mid-packet keeps the grant; there is no timeout.

## Timing
- Reset values:
  - state=IDLE, last_grant=S01 (so S00 wins the first round-robin).
  - GRANT=0, S00/S01_AXIS_TREADY=0, M_AXIS_TVALID=0.
  - M_AXIS_TDATA/TSTRB/TUSER=0, M_AXIS_TLAST=0.
- Grant latency: a TVALID first seen in IDLE at cycle 0 gives GRANT and TREADY at cycle 1. With M_AXIS_TREADY high, the first beat is accepted at cycle 1 and appears on M_AXIS at cycle 2.
- Data latency through the slice: 1 cycle.
- Throughput: 1 beat/cycle sustained. Across a packet boundary with the other source waiting, the beat after TLAST is accepted the very next cycle.
- Simultaneous requests in IDLE or at TLAST: resolved by the policy, with exactly one winner.
- M_AXIS_TREADY low for k cycles: at most 2 beats are buffered and source TREADY drops the cycle after the buffer fills. No beat is lost or duplicated.

## Configuration
- AXIS_TX_ARB_STRICT_PRIO_EN defined: strict priority; S00 always wins any contention and last_grant is unused.
- AXIS_TX_ARB_STRICT_PRIO_EN undefined (default): round-robin; on contention the source not equal to last_grant wins.

## Structure
- Package axis_tx_arb_pkg: the state encoding constants (IDLE/OWN0/OWN1) and default width constants (128 data, 8 user).
- Sub-module axis_reg_slice: the 2-entry skid buffer, parameterised on total payload width (data+strb+last+user), with ports ACLK/ARESETN and S/M valid-ready.

## Test plan
- Single source: S00 sends a 4-beat packet, TDATA 0x1..0x4, M_AXIS_TREADY=1. Required: M_AXIS shows 0x1..0x4 on cycles 2-5, TLAST on 0x4, GRANT=01 on cycles 1-4.
- Contention in round-robin: both sources hold 2-beat packets continuously from reset. Required: output order is S00, S01, S00, S01 with no idle cycle between packets.
- Contention with AXIS_TX_ARB_STRICT_PRIO_EN: the same stimulus. Required: only S00 packets appear while S00 stays valid; S01 is served only after S00 TVALID drops.
- Backpressure: a 16-beat packet with M_AXIS_TREADY toggling 1-0-0-1 randomly. Required: all 16 beats arrive in order, unchanged, with TLAST only on beat 16.
- Single-beat packets: S01 sends 3 TLAST=1 beats back-to-back while S00 is idle. Required: 3 consecutive output beats, GRANT stays 10, then returns to 00.
- Reset mid-packet: ARESETN low for 1 cycle during beat 3 of 8. Required: the next cycle shows M_AXIS_TVALID=0, both TREADY=0 and GRANT=00, and a new packet is arbitrated normally afterwards.

Source files
------------

// File: rtl/axis_tx_arb_pkg.sv
// rtl/axis_tx_arb_pkg.sv - shared constants and helpers for the TX packet arbiter
//
// Holds the arbiter FSM state encoding, the default stream widths and the
// round-robin pick helper used when AXIS_TX_ARB_STRICT_PRIO_EN is undefined.

package axis_tx_arb_pkg;

    localparam int C_TDATA_WIDTH_DEF = 128;
    localparam int C_TUSER_WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Returns the winning source index (0 = S00, 1 = S01); the caller only
    // uses the result when at least one source is valid.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last_grant);
        if (v0 && v1) begin
            return !last_grant;
        end
        return !v0;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - 2-entry full-throughput skid buffer
//
// Ports:
//   ACLK, ARESETN          clock, synchronous active-low reset
//   S_VALID/S_READY        upstream handshake; S_READY is registered ("not full")
//   S_PAYLOAD              upstream payload (C_WIDTH bits)
//   M_VALID/M_READY        downstream handshake; M_VALID driven from a register
//   M_PAYLOAD              downstream payload, registered (resets to 0)

module axis_reg_slice #(
    parameter int C_WIDTH = 8
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               S_VALID,
    output logic               S_READY,
    input  logic [C_WIDTH-1:0] S_PAYLOAD,
    output logic               M_VALID,
    input  logic               M_READY,
    output logic [C_WIDTH-1:0] M_PAYLOAD
);

    logic [1:0]         count_q, count_d;
    logic               ready_q, ready_d;
    logic [C_WIDTH-1:0] head_q, head_d;
    logic [C_WIDTH-1:0] skid_q, skid_d;
    logic               push, pop;

    always_comb begin
        push    = S_VALID && ready_q;
        pop     = (count_q != 2'd0) && M_READY;
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
        // head_q is always the oldest beat; skid_q only holds the second
        // beat while downstream is stalled. A full buffer cannot push.
        if (pop) begin
            if (count_q == 2'd2) begin
                head_d = skid_q;
            end else if (push) begin
                head_d = S_PAYLOAD;
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_d = S_PAYLOAD;
            end else begin
                skid_d = S_PAYLOAD;
            end
        end
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            count_q <= 2'd0;
            ready_q <= 1'b1;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign S_READY   = ready_q;
    assign M_VALID   = (count_q != 2'd0);
    assign M_PAYLOAD = head_q;

endmodule

// File: rtl/axis_tx_pkt_arbiter.sv
// rtl/axis_tx_pkt_arbiter.sv - packet-granular 2:1 AXI-Stream TX arbiter with output skid buffer
//
// Ports:
//   ACLK, ARESETN                  clock, synchronous active-low reset
//   S00_AXIS_*, S01_AXIS_*         two source streams (TVALID/TREADY/TDATA/TSTRB/TLAST/TUSER)
//   M_AXIS_*                       merged registered output stream
//   GRANT                          one-hot owner (bit0 = S00, bit1 = S01), 0 when idle
// Build option: AXIS_TX_ARB_STRICT_PRIO_EN selects strict S00 priority
// instead of round-robin.

module axis_tx_pkt_arbiter
    import axis_tx_arb_pkg::*;
#(
    parameter int C_TDATA_WIDTH = C_TDATA_WIDTH_DEF,
    parameter int C_TUSER_WIDTH = C_TUSER_WIDTH_DEF
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       S00_AXIS_TVALID,
    output logic                       S00_AXIS_TREADY,
    input  logic [C_TDATA_WIDTH-1:0]   S00_AXIS_TDATA,
    input  logic [C_TDATA_WIDTH/8-1:0] S00_AXIS_TSTRB,
    input  logic                       S00_AXIS_TLAST,
    input  logic [C_TUSER_WIDTH-1:0]   S00_AXIS_TUSER,
    input  logic                       S01_AXIS_TVALID,
    output logic                       S01_AXIS_TREADY,
    input  logic [C_TDATA_WIDTH-1:0]   S01_AXIS_TDATA,
    input  logic [C_TDATA_WIDTH/8-1:0] S01_AXIS_TSTRB,
    input  logic                       S01_AXIS_TLAST,
    input  logic [C_TUSER_WIDTH-1:0]   S01_AXIS_TUSER,
    output logic                       M_AXIS_TVALID,
    input  logic                       M_AXIS_TREADY,
    output logic [C_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                       M_AXIS_TLAST,
    output logic [C_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic [1:0]                 GRANT
);

    localparam int C_PAYLOAD_WIDTH = C_TDATA_WIDTH + C_TDATA_WIDTH / 8 + 1 + C_TUSER_WIDTH;

    logic [1:0]                 state_q, state_d;
    logic                       mid_pkt_q, mid_pkt_d;
    logic                       own, own_src;
    logic                       sel_valid, sel_last;
    logic [C_PAYLOAD_WIDTH-1:0] sel_payload, m_payload;
    logic                       slice_ready;
    logic                       beat_acc, pkt_done, abandon, any_valid, winner;

`ifndef AXIS_TX_ARB_STRICT_PRIO_EN
    logic last_grant_q, last_grant_d;
`endif

    always_comb begin
        own_src     = (state_q == ST_OWN1);
        own         = (state_q == ST_OWN0) || own_src;
        sel_valid   = own && (own_src ? S01_AXIS_TVALID : S00_AXIS_TVALID);
        sel_last    = own_src ? S01_AXIS_TLAST : S00_AXIS_TLAST;
        sel_payload = own_src ? {S01_AXIS_TDATA, S01_AXIS_TSTRB, S01_AXIS_TLAST, S01_AXIS_TUSER}
                              : {S00_AXIS_TDATA, S00_AXIS_TSTRB, S00_AXIS_TLAST, S00_AXIS_TUSER};
        beat_acc    = sel_valid && slice_ready;
        pkt_done    = beat_acc && sel_last;
        // A grant carried over from a TLAST re-arbitration has not started a
        // packet yet; if its owner has nothing to send, hand the grant back
        // instead of parking on an idle source.
        abandon     = own && !mid_pkt_q && !sel_valid;
        any_valid   = S00_AXIS_TVALID || S01_AXIS_TVALID;
`ifdef AXIS_TX_ARB_STRICT_PRIO_EN
        winner      = !S00_AXIS_TVALID;
`else
        last_grant_d = pkt_done ? own_src : last_grant_q;
        winner       = rr_pick(S00_AXIS_TVALID, S01_AXIS_TVALID, last_grant_d);
`endif

        state_d = state_q;
        if ((state_q == ST_IDLE) || pkt_done || abandon) begin
            state_d = !any_valid ? ST_IDLE : (winner ? ST_OWN1 : ST_OWN0);
        end

        mid_pkt_d = mid_pkt_q;
        if (pkt_done) begin
            mid_pkt_d = 1'b0;
        end else if (beat_acc) begin
            mid_pkt_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            mid_pkt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mid_pkt_q <= mid_pkt_d;
        end
    end

`ifndef AXIS_TX_ARB_STRICT_PRIO_EN
    // Resets to S01 so that S00 wins the first contended round.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    axis_reg_slice #(
        .C_WIDTH (C_PAYLOAD_WIDTH)
    ) u_slice (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .S_VALID   (sel_valid),
        .S_READY   (slice_ready),
        .S_PAYLOAD (sel_payload),
        .M_VALID   (M_AXIS_TVALID),
        .M_READY   (M_AXIS_TREADY),
        .M_PAYLOAD (m_payload)
    );

    assign {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TUSER} = m_payload;
    assign S00_AXIS_TREADY = (state_q == ST_OWN0) && slice_ready;
    assign S01_AXIS_TREADY = (state_q == ST_OWN1) && slice_ready;
    assign GRANT           = {state_q == ST_OWN1, state_q == ST_OWN0};

endmodule

// File: tb/tb_axis_tx_pkt_arbiter.sv
// tb/tb_axis_tx_pkt_arbiter.sv - self-checking bench for axis_tx_pkt_arbiter

module tb_axis_tx_pkt_arbiter;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
        logic [7:0]   user;
    } beat_t;

    typedef struct {
        logic       rstn;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       mrdy;
        logic [1:0] grant;
        logic       care_grant;
        logic       rdy0;
        logic       mvalid;
        logic       care_data;
        logic [7:0] mdata;
        logic       mlast;
    } vec_t;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         s00_tvalid, s01_tvalid, s00_tready, s01_tready;
    logic [127:0] s00_tdata, s01_tdata, m_tdata;
    logic [15:0]  s00_tstrb, s01_tstrb, m_tstrb;
    logic         s00_tlast, s01_tlast, m_tlast;
    logic [7:0]   s00_tuser, s01_tuser, m_tuser;
    logic         m_tvalid, m_tready;
    logic [1:0]   grant;

    always #5 aclk = ~aclk;

    axis_tx_pkt_arbiter dut (
        .ACLK            (aclk),
        .ARESETN         (aresetn),
        .S00_AXIS_TVALID (s00_tvalid),
        .S00_AXIS_TREADY (s00_tready),
        .S00_AXIS_TDATA  (s00_tdata),
        .S00_AXIS_TSTRB  (s00_tstrb),
        .S00_AXIS_TLAST  (s00_tlast),
        .S00_AXIS_TUSER  (s00_tuser),
        .S01_AXIS_TVALID (s01_tvalid),
        .S01_AXIS_TREADY (s01_tready),
        .S01_AXIS_TDATA  (s01_tdata),
        .S01_AXIS_TSTRB  (s01_tstrb),
        .S01_AXIS_TLAST  (s01_tlast),
        .S01_AXIS_TUSER  (s01_tuser),
        .M_AXIS_TVALID   (m_tvalid),
        .M_AXIS_TREADY   (m_tready),
        .M_AXIS_TDATA    (m_tdata),
        .M_AXIS_TSTRB    (m_tstrb),
        .M_AXIS_TLAST    (m_tlast),
        .M_AXIS_TUSER    (m_tuser),
        .GRANT           (grant)
    );

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          first_out, last_out, open_src;
    int unsigned vprob, rprob;
    bit          auto_drv = 0;
    bit          hold0, hold1;
    beat_t       sq0[$], sq1[$], eq0[$], eq1[$];
    int          order[$], exp_order[$];
    vec_t        tbl[8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_pkt(input int src, input int len, input int pid);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {8'(src), 16'(pid), 16'(i), 32'($urandom), 32'($urandom), 24'($urandom)};
            b.strb = 16'($urandom);
            b.last = (i == len - 1);
            b.user = 8'($urandom);
            if (src == 0) begin sq0.push_back(b); eq0.push_back(b); end
            else          begin sq1.push_back(b); eq1.push_back(b); end
        end
    endtask

    task automatic check_out();
        beat_t got, exp;
        int    src;
        got = {m_tdata, m_tstrb, m_tlast, m_tuser};
        src = int'(m_tdata[127:120]);
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (open_src >= 0) chk("no_interleave", 256'(src), 256'(open_src));
        exp = '0;
        if (src == 0 && eq0.size() > 0) exp = eq0.pop_front();
        else if (src == 1 && eq1.size() > 0) exp = eq1.pop_front();
        chk("out_beat", 256'(got), 256'(exp));
        if (m_tlast) begin
            order.push_back(src);
            open_src = -1;
        end else begin
            open_src = src;
        end
    endtask

    task automatic cycle();
        bit acc0, acc1;
        @(posedge aclk);
        #1;
        cyc++;
        if (auto_drv) begin
            if (!hold0) s00_tvalid = (sq0.size() > 0) && ($urandom_range(0, 99) < vprob);
            if (s00_tvalid) {s00_tdata, s00_tstrb, s00_tlast, s00_tuser} = sq0[0];
            if (!hold1) s01_tvalid = (sq1.size() > 0) && ($urandom_range(0, 99) < vprob);
            if (s01_tvalid) {s01_tdata, s01_tstrb, s01_tlast, s01_tuser} = sq1[0];
            m_tready = ($urandom_range(0, 99) < rprob);
        end
        @(negedge aclk);
        if (aresetn) begin
            acc0 = s00_tvalid && s00_tready;
            acc1 = s01_tvalid && s01_tready;
            if (acc0) void'(sq0.pop_front());
            if (acc1) void'(sq1.pop_front());
            hold0 = s00_tvalid && !acc0;
            hold1 = s01_tvalid && !acc1;
            if (m_tvalid && m_tready) check_out();
        end
    endtask

    task automatic clear_model();
        sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
        order.delete(); exp_order.delete();
        hold0 = 0; hold1 = 0;
        open_src = -1; first_out = -1; last_out = -1;
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn = 0; s00_tvalid = 0; s01_tvalid = 0;
        @(posedge aclk);
        #1;
        aresetn = 1;
        clear_model();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((sq0.size() + sq1.size() + eq0.size() + eq1.size()) > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk(name, 256'(n < budget), 256'(1));
    endtask

    task automatic chk_order();
        chk("order_len", 256'(order.size()), 256'(exp_order.size()));
        for (int i = 0; i < order.size() && i < exp_order.size(); i++)
            chk("order", 256'(order[i]), 256'(exp_order[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        aresetn = 0; m_tready = 0;
        s00_tvalid = 0; s00_tdata = '0; s00_tstrb = '0; s00_tlast = 0; s00_tuser = '0;
        s01_tvalid = 0; s01_tdata = '0; s01_tstrb = '0; s01_tlast = 0; s01_tuser = '0;
        clear_model();
        repeat (2) @(posedge aclk);

        // Reset values, then a 4-beat S00 packet with cycle-exact latencies.
        tbl[0] = '{0, 0, 8'd0, 0, 1, 2'b00, 1, 0, 0, 1, 8'd0, 0};
        tbl[1] = '{1, 1, 8'd1, 0, 1, 2'b00, 1, 0, 0, 0, 8'd0, 0};
        tbl[2] = '{1, 1, 8'd1, 0, 1, 2'b01, 1, 1, 0, 0, 8'd0, 0};
        tbl[3] = '{1, 1, 8'd2, 0, 1, 2'b01, 1, 1, 1, 1, 8'd1, 0};
        tbl[4] = '{1, 1, 8'd3, 0, 1, 2'b01, 1, 1, 1, 1, 8'd2, 0};
        tbl[5] = '{1, 1, 8'd4, 1, 1, 2'b01, 1, 1, 1, 1, 8'd3, 0};
        tbl[6] = '{1, 0, 8'd0, 0, 1, 2'b00, 0, 0, 1, 1, 8'd4, 1};
        tbl[7] = '{1, 0, 8'd0, 0, 1, 2'b00, 1, 0, 0, 0, 8'd0, 0};
        for (int i = 0; i < 8; i++) begin
            @(posedge aclk);
            #1;
            aresetn    = tbl[i].rstn;
            s00_tvalid = tbl[i].v0;
            s00_tdata  = 128'(tbl[i].d0);
            s00_tstrb  = '1;
            s00_tlast  = tbl[i].l0;
            m_tready   = tbl[i].mrdy;
            @(negedge aclk);
            if (tbl[i].care_grant) begin
                chk("tbl_grant", 256'(grant), 256'(tbl[i].grant));
                chk("tbl_s00_tready", 256'(s00_tready), 256'(tbl[i].rdy0));
            end
            chk("tbl_s01_tready", 256'(s01_tready), 256'(0));
            chk("tbl_m_tvalid", 256'(m_tvalid), 256'(tbl[i].mvalid));
            if (tbl[i].care_data) begin
                chk("tbl_m_tdata", 256'(m_tdata), 256'(tbl[i].mdata));
                chk("tbl_m_tlast", 256'(m_tlast), 256'(tbl[i].mlast));
            end
        end

        auto_drv = 1;

        // Contention: both sources hold four 2-beat packets from reset.
        do_reset();
        for (int p = 0; p < 4; p++) begin add_pkt(0, 2, p); add_pkt(1, 2, p); end
        vprob = 100; rprob = 100;
        drain("drain_contention", 200);
`ifdef AXIS_TX_ARB_STRICT_PRIO_EN
        for (int p = 0; p < 4; p++) exp_order.push_back(0);
        for (int p = 0; p < 4; p++) exp_order.push_back(1);
`else
        begin
            int n0 = 4, n1 = 4, lastg = 1, pick;
            while (n0 + n1 > 0) begin
                pick = (n0 > 0 && n1 > 0) ? 1 - lastg : (n0 > 0 ? 0 : 1);
                exp_order.push_back(pick);
                if (pick == 0) n0--; else n1--;
                lastg = pick;
            end
        end
        chk("contention_no_bubble", 256'(last_out - first_out + 1), 256'(16));
`endif
        chk_order();

        // Backpressure: one 16-beat packet, random downstream stalls.
        do_reset();
        add_pkt(0, 16, 7);
        vprob = 100; rprob = 50;
        drain("drain_backpressure", 400);
        exp_order.push_back(0);
        chk_order();

        // Single-beat packets from S01 back to back.
        do_reset();
        for (int p = 0; p < 3; p++) add_pkt(1, 1, p);
        vprob = 100; rprob = 100;
        drain("drain_single_beat", 50);
        chk("single_beat_consecutive", 256'(last_out - first_out + 1), 256'(3));
        repeat (3) exp_order.push_back(1);
        chk_order();
        cycle();
        cycle();
        chk("single_beat_grant_idle", 256'(grant), 256'(0));

        // Reset asserted while beat 3 of an 8-beat packet is presented.
        do_reset();
        add_pkt(0, 8, 3);
        vprob = 100; rprob = 100;
        begin
            int n = 0;
            while (sq0.size() > 6 && n < 50) begin cycle(); n++; end
            chk("reset_mid_reach", 256'(n < 50), 256'(1));
        end
        @(posedge aclk);
        #1;
        aresetn = 0;
        s00_tvalid = 1;
        {s00_tdata, s00_tstrb, s00_tlast, s00_tuser} = sq0[0];
        @(posedge aclk);
        #1;
        aresetn = 1;
        s00_tvalid = 0;
        @(negedge aclk);
        chk("rst_m_tvalid", 256'(m_tvalid), 256'(0));
        chk("rst_s00_tready", 256'(s00_tready), 256'(0));
        chk("rst_s01_tready", 256'(s01_tready), 256'(0));
        chk("rst_grant", 256'(grant), 256'(0));
        clear_model();
        add_pkt(0, 3, 9);
        drain("drain_after_reset", 50);
        exp_order.push_back(0);
        chk_order();

        // Randomized traffic from both sources with gaps and stalls.
        do_reset();
        for (int p = 0; p < 30; p++) add_pkt(int'($urandom_range(0, 1)), int'($urandom_range(1, 6)), 100 + p);
        vprob = 60; rprob = 70;
        drain("drain_random", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
